// File: rtl/alu_result_stage_pkg.sv
// Shared processor definitions: opcode constants, flag bit positions,
// result-stage FIFO state encoding and a flag merge helper.
package alu_result_stage_pkg;

    // Instruction opcodes (4-bit encoding)
    localparam logic [3:0] OP_ADD    = 4'b0000;
    localparam logic [3:0] OP_SUB    = 4'b0001;
    localparam logic [3:0] OP_XOR    = 4'b0010;
    localparam logic [3:0] OP_RED    = 4'b0011;
    localparam logic [3:0] OP_SLL    = 4'b0100;
    localparam logic [3:0] OP_SRA    = 4'b0101;
    localparam logic [3:0] OP_ROR    = 4'b0110;
    localparam logic [3:0] OP_PADDSB = 4'b0111;
    localparam logic [3:0] OP_LD     = 4'b1000;
    localparam logic [3:0] OP_ST     = 4'b1001;
    localparam logic [3:0] OP_BR     = 4'b1100;

    // Bit positions inside the {Z,V,N} flag register
    localparam int FLAG_Z = 2;
    localparam int FLAG_V = 1;
    localparam int FLAG_N = 0;

    // Result-stage skid buffer occupancy
    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_ONE   = 2'b01,
        ST_FULL  = 2'b10
    } fifo_state_e;

    // Replace only the flag bits selected by mask with the new values
    function automatic logic [2:0] flag_merge(input logic [2:0] old_flags,
                                              input logic [2:0] mask,
                                              input logic [2:0] new_flags);
        return (old_flags & ~mask) | (new_flags & mask);
    endfunction

endpackage

// File: rtl/alu_result_stage_flag_calc.sv
// Combinational flag computation: decides which flags an opcode writes and
// what values the issued result produces for them.
module alu_flag_calc
    import alu_result_stage_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int OPW   = 4
) (
    input  logic [OPW-1:0]   opcode,
    input  logic [WIDTH-1:0] result,
    input  logic             ovf,
    output logic [2:0]       wr_mask,
    output logic [2:0]       new_flags
);

    // Flag values from the result, write mask from the opcode class
    always_comb begin
        new_flags         = 3'b000;
        wr_mask           = 3'b000;
        new_flags[FLAG_Z] = (result == {WIDTH{1'b0}});
        new_flags[FLAG_V] = ovf;
        new_flags[FLAG_N] = result[WIDTH-1];
        case (opcode)
            OPW'(OP_ADD),
            OPW'(OP_SUB): wr_mask = 3'b111;
            OPW'(OP_XOR),
            OPW'(OP_SLL),
            OPW'(OP_SRA),
            OPW'(OP_ROR): wr_mask[FLAG_Z] = 1'b1;
            default:      wr_mask = 3'b000;
        endcase
    end

endmodule

// File: rtl/alu_result_stage.sv
// ALU result stage: two-entry skid buffer between the saturating ALU and
// writeback, owning the architectural {Z,V,N} flag register. Flags are
// written from the entry leaving the buffer.
module alu_result_stage
    import alu_result_stage_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int OPW   = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [OPW-1:0]   in_opcode,
    input  logic [WIDTH-1:0] in_result,
    input  logic             in_ovf,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic [OPW-1:0]   out_opcode,
    output logic [2:0]       flags
);

    fifo_state_e      state_r;
    fifo_state_e      state_next_s;
    logic             in_ready_r;
    logic             out_valid_r;
    logic             accept_s;
    logic             issue_s;
    logic             load_head_in_s;
    logic             load_tail_s;
    logic             head_from_tail_s;

    logic [WIDTH-1:0] head_result_r;
    logic [OPW-1:0]   head_opcode_r;
    logic             head_ovf_r;
    logic [WIDTH-1:0] tail_result_r;
    logic [OPW-1:0]   tail_opcode_r;
    logic             tail_ovf_r;

    logic [2:0]       flags_r;
    logic [2:0]       wr_mask_s;
    logic [2:0]       new_flags_s;

    assign accept_s = in_valid & in_ready_r;
    assign issue_s  = out_valid_r & out_ready;

    // Next occupancy and slot-load controls from accept/issue/flush
    always_comb begin
        state_next_s     = state_r;
        load_head_in_s   = 1'b0;
        load_tail_s      = 1'b0;
        head_from_tail_s = 1'b0;
        if (flush) begin
            state_next_s = ST_EMPTY;
        end else begin
            case (state_r)
                ST_EMPTY: begin
                    if (accept_s) begin
                        state_next_s   = ST_ONE;
                        load_head_in_s = 1'b1;
                    end else begin
                        state_next_s = ST_EMPTY;
                    end
                end
                ST_ONE: begin
                    if (accept_s && issue_s) begin
                        // head leaves, new entry takes its place
                        state_next_s   = ST_ONE;
                        load_head_in_s = 1'b1;
                    end else if (accept_s) begin
                        state_next_s = ST_FULL;
                        load_tail_s  = 1'b1;
                    end else if (issue_s) begin
                        state_next_s = ST_EMPTY;
                    end else begin
                        state_next_s = ST_ONE;
                    end
                end
                ST_FULL: begin
                    if (issue_s) begin
                        state_next_s     = ST_ONE;
                        head_from_tail_s = 1'b1;
                    end else begin
                        state_next_s = ST_FULL;
                    end
                end
                default: state_next_s = ST_EMPTY;
            endcase
        end
    end

    // Occupancy register plus handshake outputs registered from next state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_EMPTY;
            in_ready_r  <= 1'b0;
            out_valid_r <= 1'b0;
        end else begin
            state_r     <= state_next_s;
            in_ready_r  <= (state_next_s != ST_FULL);
            out_valid_r <= (state_next_s != ST_EMPTY);
        end
    end

    // Entry storage: head slot feeds the outputs, tail slot is the skid
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_result_r <= {WIDTH{1'b0}};
            head_opcode_r <= {OPW{1'b0}};
            head_ovf_r    <= 1'b0;
            tail_result_r <= {WIDTH{1'b0}};
            tail_opcode_r <= {OPW{1'b0}};
            tail_ovf_r    <= 1'b0;
        end else begin
            if (load_head_in_s) begin
                head_result_r <= in_result;
                head_opcode_r <= in_opcode;
                head_ovf_r    <= in_ovf;
            end else if (head_from_tail_s) begin
                head_result_r <= tail_result_r;
                head_opcode_r <= tail_opcode_r;
                head_ovf_r    <= tail_ovf_r;
            end else begin
                head_result_r <= head_result_r;
                head_opcode_r <= head_opcode_r;
                head_ovf_r    <= head_ovf_r;
            end
            if (load_tail_s) begin
                tail_result_r <= in_result;
                tail_opcode_r <= in_opcode;
                tail_ovf_r    <= in_ovf;
            end else begin
                tail_result_r <= tail_result_r;
                tail_opcode_r <= tail_opcode_r;
                tail_ovf_r    <= tail_ovf_r;
            end
        end
    end

    alu_flag_calc #(
        .WIDTH (WIDTH),
        .OPW   (OPW)
    ) u_flag_calc (
        .opcode    (head_opcode_r),
        .result    (head_result_r),
        .ovf       (head_ovf_r),
        .wr_mask   (wr_mask_s),
        .new_flags (new_flags_s)
    );

    // Flag register: written by the issuing entry unless flushed
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flags_r <= 3'b000;
        end else if (issue_s && !flush) begin
            flags_r <= flag_merge(flags_r, wr_mask_s, new_flags_s);
        end else begin
            flags_r <= flags_r;
        end
    end

    assign in_ready   = in_ready_r;
    assign out_valid  = out_valid_r;
    assign out_result = head_result_r;
    assign out_opcode = head_opcode_r;
    assign flags      = flags_r;

endmodule

// File: tb/tb_alu_result_stage.sv
// Directed bench for alu_result_stage: handshake, ordering, flag update
// rules, flush and asynchronous reset behaviour.
module tb_alu_result_stage;
    import alu_result_stage_pkg::*;

    localparam int WIDTH = 16;
    localparam int OPW   = 4;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [OPW-1:0]   in_opcode;
    logic [WIDTH-1:0] in_result;
    logic             in_ovf;
    logic             flush;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_result;
    logic [OPW-1:0]   out_opcode;
    logic [2:0]       flags;

    int vectors;
    int miscompares;

    alu_result_stage #(
        .WIDTH (WIDTH),
        .OPW   (OPW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_opcode  (in_opcode),
        .in_result  (in_result),
        .in_ovf     (in_ovf),
        .flush      (flush),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_opcode (out_opcode),
        .flags      (flags)
    );

    // 10 ns clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Advance to just after the next rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [3:0] op, input logic [15:0] res, input logic ovf);
        in_valid  = v;
        in_opcode = op;
        in_result = res;
        in_ovf    = ovf;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        flush       = 1'b0;
        out_ready   = 1'b0;
        drive(1'b0, OP_ADD, 16'h0000, 1'b0);

        // Reset state
        #3;
        chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_result", {16'd0, out_result}, 32'd0);
        chk("rst_out_opcode", {28'd0, out_opcode}, 32'd0);
        chk("rst_flags", {29'd0, flags}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("rel_in_ready_low", {31'd0, in_ready}, 32'd0);
        step();
        chk("rel_in_ready_high", {31'd0, in_ready}, 32'd1);

        // ADD saturated positive: result next cycle, flags {Z,V,N}=010 after issue
        out_ready = 1'b1;
        drive(1'b1, OP_ADD, 16'h7FFF, 1'b1);
        step();
        drive(1'b0, OP_ADD, 16'h0000, 1'b0);
        chk("add_out_valid", {31'd0, out_valid}, 32'd1);
        chk("add_out_result", {16'd0, out_result}, 32'h7FFF);
        chk("add_flags_before", {29'd0, flags}, 32'd0);
        step();
        chk("add_flags", {29'd0, flags}, 32'b010);
        chk("add_drained", {31'd0, out_valid}, 32'd0);

        // SUB zero then XOR 8000 back to back: flags 100 then 000
        drive(1'b1, OP_SUB, 16'h0000, 1'b0);
        step();
        drive(1'b1, OP_XOR, 16'h8000, 1'b0);
        chk("sub_out_result", {16'd0, out_result}, 32'h0000);
        step();
        drive(1'b0, OP_ADD, 16'h0000, 1'b0);
        chk("sub_flags", {29'd0, flags}, 32'b100);
        chk("xor_out_result", {16'd0, out_result}, 32'h8000);
        step();
        chk("xor_flags", {29'd0, flags}, 32'b000);
        chk("xor_drained", {31'd0, out_valid}, 32'd0);

        // SUB negative saturated then RED: 011 then unchanged
        drive(1'b1, OP_SUB, 16'h8000, 1'b1);
        step();
        drive(1'b0, OP_ADD, 16'h0000, 1'b0);
        step();
        chk("subneg_flags", {29'd0, flags}, 32'b011);
        drive(1'b1, OP_RED, 16'h0000, 1'b0);
        step();
        drive(1'b0, OP_ADD, 16'h0000, 1'b0);
        chk("red_out_opcode", {28'd0, out_opcode}, {28'd0, OP_RED});
        step();
        chk("red_flags_held", {29'd0, flags}, 32'b011);

        // Back-pressure: three accepts attempted, two taken, drain in order
        out_ready = 1'b0;
        drive(1'b1, OP_ADD, 16'h0000, 1'b0);
        step();
        chk("bp_one_ready", {31'd0, in_ready}, 32'd1);
        chk("bp_one_head", {16'd0, out_result}, 32'h0000);
        drive(1'b1, OP_SUB, 16'h2222, 1'b1);
        step();
        chk("bp_full_ready", {31'd0, in_ready}, 32'd0);
        drive(1'b1, OP_XOR, 16'h3333, 1'b0);
        step();
        chk("bp_held_ready", {31'd0, in_ready}, 32'd0);
        chk("bp_held_head", {16'd0, out_result}, 32'h0000);
        chk("bp_held_opcode", {28'd0, out_opcode}, {28'd0, OP_ADD});
        out_ready = 1'b1;
        step();
        chk("bp_drain1_head", {16'd0, out_result}, 32'h2222);
        chk("bp_drain1_ready", {31'd0, in_ready}, 32'd1);
        chk("bp_drain1_flags", {29'd0, flags}, 32'b100);
        step();
        drive(1'b0, OP_ADD, 16'h0000, 1'b0);
        chk("bp_drain2_head", {16'd0, out_result}, 32'h3333);
        chk("bp_drain2_flags", {29'd0, flags}, 32'b010);
        step();
        chk("bp_drain3_valid", {31'd0, out_valid}, 32'd0);
        chk("bp_drain3_flags", {29'd0, flags}, 32'b010);

        // Flush while FULL with an issue and an accept in the same cycle
        out_ready = 1'b0;
        drive(1'b1, OP_ADD, 16'h0000, 1'b0);
        step();
        drive(1'b1, OP_ADD, 16'h8001, 1'b1);
        step();
        chk("fl_full_ready", {31'd0, in_ready}, 32'd0);
        flush     = 1'b1;
        out_ready = 1'b1;
        drive(1'b1, OP_SUB, 16'h1234, 1'b0);
        step();
        flush = 1'b0;
        drive(1'b0, OP_ADD, 16'h0000, 1'b0);
        chk("fl_out_valid", {31'd0, out_valid}, 32'd0);
        chk("fl_in_ready", {31'd0, in_ready}, 32'd1);
        chk("fl_flags", {29'd0, flags}, 32'b010);
        step();
        chk("fl_nothing_left", {31'd0, out_valid}, 32'd0);
        chk("fl_flags_after", {29'd0, flags}, 32'b010);

        // Asynchronous reset while FULL
        out_ready = 1'b0;
        drive(1'b1, OP_SUB, 16'h8000, 1'b1);
        step();
        drive(1'b1, OP_ADD, 16'h4444, 1'b0);
        step();
        drive(1'b0, OP_ADD, 16'h0000, 1'b0);
        chk("ar_full_valid", {31'd0, out_valid}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_out_valid", {31'd0, out_valid}, 32'd0);
        chk("ar_flags", {29'd0, flags}, 32'd0);
        chk("ar_in_ready", {31'd0, in_ready}, 32'd0);
        chk("ar_out_result", {16'd0, out_result}, 32'd0);
        step();
        rst_n     = 1'b1;
        out_ready = 1'b1;
        step();
        chk("ar_rel_ready", {31'd0, in_ready}, 32'd1);
        chk("ar_rel_valid", {31'd0, out_valid}, 32'd0);
        step();
        chk("ar_rel_valid2", {31'd0, out_valid}, 32'd0);
        chk("ar_rel_flags", {29'd0, flags}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/alu_result_stage.md
ALU_RESULT_STAGE -- requirements
Module: alu_result_stage

Interface
REQ-001 Parameter WIDTH, default 16, datapath width of result and operands.
REQ-002 Parameter OPW, default 4, opcode width.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 in_valid  input  1  upstream saturating adder/ALU result valid.
REQ-006 in_ready  output  1  stage can accept an entry this cycle; driven from a register.
REQ-007 in_opcode  input  OPW  instruction opcode of the entry.
REQ-008 in_result  input  WIDTH  already-saturated 16-bit result from upstream.
REQ-009 in_ovf  input  1  upstream adder saturated (positive or negative overflow).
REQ-010 flush  input  1  synchronous kill of all buffered entries.
REQ-011 out_valid  output  1  buffered entry available downstream.
REQ-012 out_ready  input  1  downstream accepts entry.
REQ-013 out_result  output  WIDTH  head entry result.
REQ-014 out_opcode  output  OPW  head entry opcode.
REQ-015 flags  output  3  architectural flag register {Z,V,N}.

Function
REQ-016 The stage SHALL be a 2-entry FIFO (skid buffer) with states EMPTY, ONE, FULL.
REQ-017 Accept = in_valid & in_ready; issue = out_valid & out_ready.
REQ-018 in_ready SHALL be 1 in EMPTY and ONE, 0 in FULL.
REQ-019 out_valid SHALL be 1 in ONE and FULL; out_result/out_opcode SHALL show the oldest entry.
REQ-020 Transitions: EMPTY+accept->ONE; ONE+accept only->FULL; ONE+issue only->EMPTY; ONE+accept+issue->ONE (new entry becomes head next cycle); FULL+issue->ONE; otherwise hold.
REQ-021 Latency: an entry accepted in cycle n SHALL be presented with out_valid=1 in cycle n+1 at the earliest; order strictly preserved; no entry dropped or duplicated except by flush/reset.
REQ-022 Each entry SHALL store result, opcode, and ovf bit.
REQ-023 Flags SHALL update only on issue, from the issued entry: Z = (result==0), N = result[WIDTH-1], V = stored ovf.
REQ-024 ADD (0000) and SUB (0001) SHALL write Z, V and N.
REQ-025 XOR (0010), SLL (0100), SRA (0101), ROR (0110) SHALL write Z only; V and N hold.
REQ-026 All other opcodes (RED, PADDSB, memory, control) SHALL leave flags unchanged.
REQ-027 flags SHALL be the registered value; a flag write becomes visible the cycle after issue.
REQ-028 flush=1 SHALL force state EMPTY next cycle, discard any accept in the same cycle, and suppress the flag write of any issue in the same cycle.
REQ-029 Stored entry contents in discarded slots are don't-care; outputs qualified only by out_valid.

Reset
REQ-030 rst_n=0 SHALL asynchronously force state EMPTY, in_ready=0 while asserted, out_valid=0, out_result=0, out_opcode=0, flags=3'b000.
REQ-031 in_ready SHALL rise the first clock edge after rst_n deasserts; reset mid-transfer SHALL discard all entries with no flag write.

Structure
REQ-032 Opcode constants, flag bit indices (Z=2, V=1, N=0) and FIFO state encoding SHALL live in the shared processor package.
REQ-033 Flag computation (opcode, result, ovf -> write-enable mask and new flag values) SHALL be a combinational sub-module alu_flag_calc.

Verification
REQ-034 ADD in_result=16'h7FFF, in_ovf=1, out_ready=1 -> out_result 16'h7FFF one cycle later; flags 3'b010 the cycle after issue.
REQ-035 SUB in_result=16'h0000, in_ovf=0, then XOR in_result=16'h8000 -> flags 3'b100 then 3'b000 (N, V held at 0).
REQ-036 out_ready=0, three back-to-back accepts attempted -> first two accepted, in_ready=0 after second, third held; releasing out_ready drains in order.
REQ-037 FULL with flush=1 and out_ready=1 same cycle -> EMPTY next cycle, flags unchanged, in_ready=1.
REQ-038 SUB in_result=16'h8000, in_ovf=1, then RED in_result=16'h0000 -> flags 3'b011 after SUB, unchanged after RED.
REQ-039 rst_n pulsed low while FULL -> out_valid=0 and flags=3'b000 immediately, no entry emerges after release.
